// File: rtl/xcl_clock_gen_if.sv
// XCL clock-generator status bundle: generated pixel clock plus lock flag.
// The generator drives both signals through the master modport.
`timescale 1ns/1ps
interface xcl_clock_gen_if;
   logic clk_25m;
   logic locked;

   modport master (output clk_25m, output locked);
   modport slave  (input  clk_25m, input  locked);
endinterface

// File: rtl/xcl_clock_gen.sv
// Integer divider producing the e-ink XCL pixel clock from a reference clock,
// with a lock flag raised after LOCK_CYCLES stable output periods.
`timescale 1ns/1ps
module xcl_clock_gen #(
   parameter int DIV         = 4,
   parameter int LOCK_CYCLES = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   xcl_clock_gen_if.master xcl
);

   localparam int CNT_W = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
   localparam int LK_W  = ($clog2(LOCK_CYCLES + 1) < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
   localparam logic [LK_W-1:0]  LK_MAX   = LK_W'(LOCK_CYCLES);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("xcl_clock_gen: DIV must be >= 2");
      end
      if (LOCK_CYCLES < 1) begin : g_bad_lock
         $error("xcl_clock_gen: LOCK_CYCLES must be >= 1");
      end
   endgenerate

   logic [1:0]       r_sync;
   logic             w_div_rst_n;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pos_q;
   logic             w_neg_q;
   logic             w_clk_25m;
   logic [LK_W-1:0]  r_lock_cnt;
   logic             r_locked;

   // Assertion is immediate; only the release edge is synchronized to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], 1'b1};
      end
   end

   assign w_div_rst_n = r_sync[1];

   always_ff @(posedge clk or negedge w_div_rst_n) begin
      if (!w_div_rst_n) begin
         r_cnt   <= '0;
         r_pos_q <= 1'b0;
      end else begin
         r_pos_q <= (r_cnt < CNT_HALF);
         if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Odd ratios stretch the high phase by half a reference period.
   generate
      if ((DIV % 2) != 0) begin : g_odd
         logic r_neg_q;
         always_ff @(negedge clk or negedge w_div_rst_n) begin
            if (!w_div_rst_n) begin
               r_neg_q <= 1'b0;
            end else begin
               r_neg_q <= r_pos_q;
            end
         end
         assign w_neg_q = r_neg_q;
      end else begin : g_even
         assign w_neg_q = 1'b0;
      end
   endgenerate

   assign w_clk_25m = r_pos_q | w_neg_q;

   always_ff @(posedge w_clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
      end else if (r_lock_cnt != LK_MAX) begin
         r_lock_cnt <= r_lock_cnt + LK_W'(1);
         if (r_lock_cnt == LK_MAX - LK_W'(1)) begin
            r_locked <= 1'b1;
         end
      end
   end

   assign xcl.clk_25m = w_clk_25m;
   assign xcl.locked  = r_locked;

endmodule

// File: tb/tb_xcl_clock_gen.sv
// Directed bench: three generator instances (DIV 4/5/2) checked at hand-computed
// absolute times, plus edge-timestamp analysis of period and high time.
`timescale 1ns/1ps
module tb_xcl_clock_gen;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   xcl_clock_gen_if xif4 ();
   xcl_clock_gen_if xif5 ();
   xcl_clock_gen_if xif2 ();

   xcl_clock_gen #(.DIV(4), .LOCK_CYCLES(64)) u_dut4 (.clk(clk), .rst_n(rst_n), .xcl(xif4.master));
   xcl_clock_gen #(.DIV(5), .LOCK_CYCLES(3))  u_dut5 (.clk(clk), .rst_n(rst_n), .xcl(xif5.master));
   xcl_clock_gen #(.DIV(2), .LOCK_CYCLES(1))  u_dut2 (.clk(clk), .rst_n(rst_n), .xcl(xif2.master));

   // index 0: DIV=4, 1: DIV=5, 2: DIV=2
   wire [2:0] w_ck;
   wire [2:0] w_lk;
   assign w_ck = {xif2.clk_25m, xif5.clk_25m, xif4.clk_25m};
   assign w_lk = {xif2.locked,  xif5.locked,  xif4.locked};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_mon
      time rise_t [128];
      time fall_t [128];
      int  n_rise = 0;
      int  n_fall = 0;
      int  n_lk   = 0;
      always @(posedge w_ck[gi]) if ($time >= 2) begin
         if (n_rise < 128) rise_t[n_rise[6:0]] = $time;
         n_rise++;
      end
      always @(negedge w_ck[gi]) if ($time >= 2) begin
         if (n_fall < 128) fall_t[n_fall[6:0]] = $time;
         n_fall++;
      end
      always @(w_lk[gi]) if ($time >= 2) n_lk++;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
         $display("[chk] %-16s obs=%0d exp=%0d ok", tag, obs, exp);
      end else begin
         $display("[chk] FAIL %-16s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_until(input realtime t);
      #(t - $realtime);
   endtask

   task automatic analyze(input string nm, input time r [128], input time f [128],
                          input int nr, input int per, input int hi);
      longint min_p = 64'sd1000000, max_p = 0, min_h = 64'sd1000000, max_h = 0;
      check({nm, "_nrise>=101"}, longint'(nr >= 101), 1);
      check({nm, "_rise0"}, longint'(r[0]), 1025);
      for (int k = 0; k < 100; k++) begin
         longint p, h;
         p = longint'(r[k+1]) - longint'(r[k]);
         h = longint'(f[k]) - longint'(r[k]);
         if (p < min_p) min_p = p;
         if (p > max_p) max_p = p;
         if (h < min_h) min_h = h;
         if (h > max_h) max_h = h;
      end
      check({nm, "_per_min"}, min_p, per);
      check({nm, "_per_max"}, max_p, per);
      check({nm, "_hi_min"},  min_h, hi);
      check({nm, "_hi_max"},  max_h, hi);
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // long reset with clk running: outputs quiet
      wait_until(500);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_ck%0d", i), longint'(w_ck[i]), 0);
         check($sformatf("rst_lk%0d", i), longint'(w_lk[i]), 0);
      end
      wait_until(1000);
      check("rst_edges_d4", g_mon[0].n_rise + g_mon[0].n_fall + g_mon[0].n_lk, 0);
      check("rst_edges_d5", g_mon[1].n_rise + g_mon[1].n_fall + g_mon[1].n_lk, 0);
      check("rst_edges_d2", g_mon[2].n_rise + g_mon[2].n_fall + g_mon[2].n_lk, 0);

      // release between edges: 1005, 1015 sync; first rise at 1025
      wait_until(1002);
      rst_n = 1'b1;
      wait_until(1022);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("pre_rise_ck%0d", i), longint'(w_ck[i]), 0);
         check($sformatf("pre_rise_lk%0d", i), longint'(w_lk[i]), 0);
      end
      wait_until(1026);
      for (int i = 0; i < 3; i++)
         check($sformatf("first_rise_ck%0d", i), longint'(w_ck[i]), 1);
      check("lk_d2_first", longint'(w_lk[2]), 1);
      check("lk_d4_early", longint'(w_lk[0]), 0);
      check("lk_d5_early", longint'(w_lk[1]), 0);

      // DIV=5, LOCK_CYCLES=3: rises 1025, 1075, 1125
      wait_until(1076);
      check("lk_d5_edge2", longint'(w_lk[1]), 0);
      wait_until(1126);
      check("lk_d5_edge3", longint'(w_lk[1]), 1);

      // DIV=4, LOCK_CYCLES=64: 63rd rise 3505, 64th rise 3545
      wait_until(3506);
      check("lk_d4_edge63", longint'(w_lk[0]), 0);
      wait_until(3546);
      check("lk_d4_edge64", longint'(w_lk[0]), 1);

      wait_until(6100);
      analyze("d4", g_mon[0].rise_t, g_mon[0].fall_t, g_mon[0].n_rise, 40, 20);
      analyze("d5", g_mon[1].rise_t, g_mon[1].fall_t, g_mon[1].n_rise, 50, 25);
      analyze("d2", g_mon[2].rise_t, g_mon[2].fall_t, g_mon[2].n_rise, 20, 10);

      // 1000 further DIV=4 output cycles: locked never toggles again
      wait_until(43546);
      check("lk_d4_hold_edges", g_mon[0].n_lk, 1);
      check("lk_d4_hold_val", longint'(w_lk[0]), 1);

      // short reset pulse 3 ns into a high phase (rise at 43625)
      wait_until(43627);
      check("mid_high_ck0", longint'(w_ck[0]), 1);
      wait_until(43628);
      rst_n = 1'b0;
      #0.1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("arst_ck%0d", i), longint'(w_ck[i]), 0);
         check($sformatf("arst_lk%0d", i), longint'(w_lk[i]), 0);
      end
      wait_until(43632);
      rst_n = 1'b1;
      wait_until(43652);
      check("re_pre_rise_ck0", longint'(w_ck[0]), 0);
      wait_until(43656);
      for (int i = 0; i < 3; i++)
         check($sformatf("re_rise_ck%0d", i), longint'(w_ck[i]), 1);
      check("re_lk_d4", longint'(w_lk[0]), 0);
      check("re_lk_d2", longint'(w_lk[2]), 1);
      wait_until(46136);
      check("re_lk_d4_e63", longint'(w_lk[0]), 0);
      wait_until(46176);
      check("re_lk_d4_e64", longint'(w_lk[0]), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
